// File: rtl/fpu_ctrl_pkg.sv
// fpu_ctrl_pkg: shared constants, shadow-pipe entry type and FP instruction decode
// Revision: 1.0
`default_nettype none

package fpu_ctrl_pkg;

  localparam logic [31:0] FPU_NOP = 32'h0000_0000;

  localparam logic [6:0] OPC_LOAD_FP = 7'b0000111;
  localparam logic [6:0] OPC_FMADD   = 7'b1000011;
  localparam logic [6:0] OPC_FMSUB   = 7'b1000111;
  localparam logic [6:0] OPC_FNMSUB  = 7'b1001011;
  localparam logic [6:0] OPC_FNMADD  = 7'b1001111;
  localparam logic [6:0] OPC_OP_FP   = 7'b1010011;

  // OP-FP groups whose result lands in the integer register file
  localparam logic [4:0] F5_FMV_FCLASS = 5'b11100;
  localparam logic [4:0] F5_FCMP       = 5'b10100;
  localparam logic [4:0] F5_FCVT_TO_X  = 5'b11000;

  localparam int REG_IDX_W = 5;
  localparam int SHADOW_ID_W = 4;

  typedef struct packed {
    logic                   valid;
    logic [SHADOW_ID_W-1:0] id;
    logic [REG_IDX_W-1:0]   rd;
    logic                   writes_f;
    logic                   to_x;
  } shadow_entry_t;

  typedef struct packed {
    logic [REG_IDX_W-1:0] rd;
    logic [REG_IDX_W-1:0] rs1;
    logic [REG_IDX_W-1:0] rs2;
    logic [REG_IDX_W-1:0] rs3;
    logic                 writes_f;
    logic                 to_x;
  } decode_t;

  function automatic decode_t decode_fp(input logic [31:0] instr);
    decode_t    d;
    logic [6:0] opc;
    logic [4:0] f5;
    logic       xgrp;
    opc  = instr[6:0];
    f5   = instr[31:27];
    xgrp = (f5 == F5_FMV_FCLASS) || (f5 == F5_FCMP) || (f5 == F5_FCVT_TO_X);
    d.rd  = instr[11:7];
    d.rs1 = instr[19:15];
    d.rs2 = instr[24:20];
    d.rs3 = instr[31:27];
    d.writes_f = (opc == OPC_LOAD_FP) || (opc == OPC_FMADD) || (opc == OPC_FMSUB) ||
                 (opc == OPC_FNMSUB) || (opc == OPC_FNMADD) ||
                 ((opc == OPC_OP_FP) && !xgrp);
    d.to_x = (opc == OPC_OP_FP) && xgrp;
    return d;
  endfunction

endpackage

`default_nettype wire

// File: rtl/fpu_scoreboard.sv
// fpu_scoreboard: one busy bit per FP register with set/clear and hazard read ports
// Revision: 1.0
`default_nettype none

module fpu_scoreboard
  import fpu_ctrl_pkg::*;
#(
  parameter int NUM_REGS = 32
) (
  input  logic                 ck,
  input  logic                 rst,
  input  logic                 set_en,
  input  logic [REG_IDX_W-1:0] set_idx,
  input  logic                 clr_en,
  input  logic [REG_IDX_W-1:0] clr_idx,
  input  logic [REG_IDX_W-1:0] rs1,
  input  logic [REG_IDX_W-1:0] rs2,
  input  logic [REG_IDX_W-1:0] rs3,
  input  logic [REG_IDX_W-1:0] rd,
  output logic                 rs1_busy,
  output logic                 rs2_busy,
  output logic                 rs3_busy,
  output logic                 rd_busy
);

  logic [NUM_REGS-1:0] sb;
  logic [NUM_REGS-1:0] sb_next;

  // Clear first, then set: the two never target the same register because WAW stalls
  always_comb begin
    sb_next = sb;
    if (clr_en) sb_next[clr_idx] = 1'b0;
    if (set_en) sb_next[set_idx] = 1'b1;
  end

  always_ff @(posedge ck) begin
    if (rst) sb <= '0;
    else     sb <= sb_next;
  end

  assign rs1_busy = sb[rs1];
  assign rs2_busy = sb[rs2];
  assign rs3_busy = sb[rs3];
  assign rd_busy  = sb[rd];

endmodule

`default_nettype wire

// File: rtl/fpu_issue_ctrl.sv
// fpu_issue_ctrl: issue/hazard control in front of the pipelined FPU with completion shadowing
// Revision: 1.0
`default_nettype none

module fpu_issue_ctrl
  import fpu_ctrl_pkg::*;
#(
  parameter int NUM_REGS        = 32,
  parameter int PIPELINE_STAGES = 4,
  parameter int X_ID_WIDTH      = SHADOW_ID_W
) (
  input  logic                  ck,
  input  logic                  rst,
  input  logic                  issue_valid,
  input  logic [31:0]           issue_instr,
  input  logic [X_ID_WIDTH-1:0] issue_id,
  output logic                  issue_ready,
  input  logic                  fpu_full,
  output logic                  fpu_enable,
  output logic [31:0]           fpu_instr,
  output logic [X_ID_WIDTH-1:0] fpu_id,
  output logic                  cmpl_valid,
  output logic [X_ID_WIDTH-1:0] cmpl_id,
  output logic                  cmpl_to_xreg,
  output logic                  busy,
  output logic [31:0]           stall_cnt
);

  generate
    if (X_ID_WIDTH != SHADOW_ID_W) begin : g_id_width_check
      $error("X_ID_WIDTH must equal fpu_ctrl_pkg::SHADOW_ID_W");
    end
  endgenerate

  decode_t       dec;
  shadow_entry_t stages [PIPELINE_STAGES];
  shadow_entry_t tail;
  logic          rs1_busy, rs2_busy, rs3_busy, rd_busy;
  logic          hazard;
  logic          accept;
  logic          retire;

  assign dec    = decode_fp(issue_instr);
  assign hazard = rs1_busy | rs2_busy | rs3_busy | (dec.writes_f & rd_busy);

  assign issue_ready = !rst && !fpu_full && !hazard;
  assign accept      = issue_valid && issue_ready;
  assign fpu_enable  = !rst && !fpu_full && (accept || busy);
  assign fpu_instr   = accept ? issue_instr : FPU_NOP;
  assign fpu_id      = accept ? issue_id : '0;

  assign tail   = stages[PIPELINE_STAGES-1];
  assign retire = fpu_enable && tail.valid;

  always_comb begin
    busy = 1'b0;
    for (int i = 0; i < PIPELINE_STAGES; i++) busy = busy | stages[i].valid;
  end

  fpu_scoreboard #(
    .NUM_REGS (NUM_REGS)
  ) u_sb (
    .ck       (ck),
    .rst      (rst),
    .set_en   (accept && dec.writes_f),
    .set_idx  (dec.rd),
    .clr_en   (retire && tail.writes_f),
    .clr_idx  (tail.rd),
    .rs1      (dec.rs1),
    .rs2      (dec.rs2),
    .rs3      (dec.rs3),
    .rd       (dec.rd),
    .rs1_busy (rs1_busy),
    .rs2_busy (rs2_busy),
    .rs3_busy (rs3_busy),
    .rd_busy  (rd_busy)
  );

  // Shadow pipe advances in lock-step with the FPU, i.e. only on enabled edges
  always_ff @(posedge ck) begin
    if (rst) begin
      for (int i = 0; i < PIPELINE_STAGES; i++) stages[i] <= '0;
    end else if (fpu_enable) begin
      if (accept) begin
        stages[0].valid    <= 1'b1;
        stages[0].id       <= issue_id;
        stages[0].rd       <= dec.rd;
        stages[0].writes_f <= dec.writes_f;
        stages[0].to_x     <= dec.to_x;
      end else begin
        stages[0] <= '0;
      end
      for (int i = 1; i < PIPELINE_STAGES; i++) stages[i] <= stages[i-1];
    end
  end

  always_ff @(posedge ck) begin
    if (rst) begin
      cmpl_valid   <= 1'b0;
      cmpl_id      <= '0;
      cmpl_to_xreg <= 1'b0;
    end else begin
      cmpl_valid   <= retire;
      cmpl_id      <= retire ? tail.id : '0;
      cmpl_to_xreg <= retire && tail.to_x;
    end
  end

  always_ff @(posedge ck) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (issue_valid && !issue_ready && (stall_cnt != 32'hFFFF_FFFF)) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end

endmodule

`default_nettype wire
